// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives the run request and ratio, and the divider returns O, TICK and BUSY.
interface clk_div_prog_if #(
    parameter int W = 4
);
    logic         EN;
    logic [W-1:0] DIV;
    logic         O;
    logic         TICK;
    logic         BUSY;

    modport master (
        output EN,
        output DIV,
        input  O,
        input  TICK,
        input  BUSY
    );

    modport slave (
        input  EN,
        input  DIV,
        output O,
        output TICK,
        output BUSY
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a registered, runt-free output.
// The ratio is shadowed at period boundaries, and start/stop are gated to whole periods.
module clk_div_prog #(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           RSTN,
    clk_div_prog_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [W-1:0] TWO = W'(2);

    state_t       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] div_q;
    logic         o_q;
    logic         tick_q;
    logic         busy_q;

    logic [W-1:0] div_sat;
    logic [W-1:0] half;
    logic [W:0]   n_m1;
    logic [W:0]   cnt_p1;
    logic         wrap;

    // Ratios 0 and 1 cannot form a high and a low phase, so they clamp to 2.
    assign div_sat = (bus.DIV < TWO) ? TWO : bus.DIV;
    assign half    = div_q >> 1;
    assign n_m1    = {1'b0, div_q} - (W+1)'(1);
    assign cnt_p1  = {1'b0, cnt_q} + (W+1)'(1);
    assign wrap    = ({1'b0, cnt_q} == n_m1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= TWO;
            o_q     <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    o_q   <= 1'b0;
                    if (bus.EN) begin
                        state_q <= RUN;
                        div_q   <= div_sat;
                        o_q     <= 1'b1;
                        tick_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        // A STOP wrap without EN ends the run; otherwise a new period begins.
                        if (state_q == STOP && !bus.EN) begin
                            state_q <= IDLE;
                            o_q     <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= bus.EN ? RUN : STOP;
                            div_q   <= div_sat;
                            o_q     <= 1'b1;
                            tick_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_p1[W-1:0];
                        state_q <= bus.EN ? RUN : STOP;
                        if (cnt_p1 == {1'b0, half}) begin
                            o_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    o_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O    = o_q;
    assign bus.TICK = tick_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a cycle table of {EN, DIV} -> {O, TICK, BUSY}
// plus hand sequences for the full-width ratio and an asynchronous reset mid-period.
module tb_clk_div_prog;

    typedef struct {
        logic       en;
        logic [3:0] div;
        logic [2:0] exp;
    } vec_t;

    logic CLK;
    logic RSTN;
    int   checks;
    int   errors;
    vec_t vt[$];

    clk_div_prog_if #(.W(4)) bus ();

    clk_div_prog #(.W(4)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add(input logic en, input logic [3:0] div, input logic [2:0] exp);
        vec_t v;
        v.en  = en;
        v.div = div;
        v.exp = exp;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {bus.O, bus.TICK, bus.BUSY};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {O,TICK,BUSY} got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] div);
        @(negedge CLK);
        bus.EN  = en;
        bus.DIV = div;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RSTN    = 1'b0;
        bus.EN  = 1'b0;
        bus.DIV = 4'd4;

        // DIV=4 steady, then 3, then 0 and 1 saturating to 2
        add(1,4,3'b111); add(1,4,3'b101); add(1,4,3'b001); add(1,4,3'b001);
        add(1,4,3'b111); add(1,4,3'b101); add(1,4,3'b001); add(1,4,3'b001);
        add(1,3,3'b111); add(1,3,3'b001); add(1,3,3'b001);
        add(1,0,3'b111); add(1,0,3'b001);
        add(1,1,3'b111); add(1,1,3'b001);
        // DIV 4 -> 6 changed at CNT=1
        add(1,4,3'b111); add(1,4,3'b101); add(1,6,3'b001); add(1,6,3'b001);
        add(1,6,3'b111); add(1,6,3'b101); add(1,6,3'b101);
        add(1,6,3'b001); add(1,6,3'b001); add(1,6,3'b001);
        // DIV 4 -> 7 -> 4 inside one period
        add(1,4,3'b111); add(1,7,3'b101); add(1,4,3'b001); add(1,4,3'b001);
        // EN dropped at CNT=1: period completes then idles
        add(1,4,3'b111); add(1,4,3'b101); add(0,4,3'b001); add(0,4,3'b001);
        add(0,4,3'b000); add(0,4,3'b000);
        // restart, EN re-raised at CNT=2 during STOP
        add(1,4,3'b111); add(1,4,3'b101); add(0,4,3'b001); add(1,4,3'b001);
        // EN re-raised exactly on the wrap edge
        add(1,4,3'b111); add(1,4,3'b101); add(0,4,3'b001); add(0,4,3'b001);
        add(1,4,3'b111); add(1,4,3'b101);
        add(0,4,3'b001); add(0,4,3'b001); add(0,4,3'b000);

        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 3'b000);
        @(negedge CLK);
        RSTN = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].en, vt[i].div);
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        // Full-width ratio: 7 high, 8 low, period 15
        for (int k = 0; k <= 30; k++) begin
            logic [2:0] e;
            step(1'b1, 4'd15);
            e = {((k % 15) < 7), ((k % 15) == 0), 1'b1};
            check($sformatf("div15_k%0d", k), e);
        end

        // Asynchronous reset in the high phase, no clock edge involved
        #1;
        RSTN = 1'b0;
        #1;
        check("async_reset", 3'b000);
        @(negedge CLK);
        RSTN    = 1'b1;
        bus.EN  = 1'b1;
        bus.DIV = 4'd4;
        @(posedge CLK);
        #1;
        check("restart_edge0", 3'b111);
        step(1'b1, 4'd4);
        check("restart_edge1", 3'b101);
        step(1'b1, 4'd4);
        check("restart_edge2", 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider with registered output.
- O drives the downstream buffer_12x/inv_12x chain that feeds a wide clock/enable load.
- Divide ratio loads through a shadow register at period boundaries only, so O never shows a runt pulse.
- Start and stop are gated to whole periods.

Parameters:
- W, 4, width of the DIV input and the internal counter. Maximum ratio is 2^W-1.

Ports:
- CLK  input  1  source clock; all flops on rising edge
- RSTN  input  1  asynchronous active-low reset
- EN  input  1  run request; sampled each CLK edge
- DIV  input  W  requested divide ratio N; values 0 and 1 saturate to 2
- O  output  1  divided clock, registered; feeds buffer_12x
- TICK  output  1  one-CLK pulse coincident with each rising edge of O
- BUSY  output  1  high while a period is in progress (RUN or STOP)

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTN is asynchronous and active-low.
- Reset values (applied immediately on RSTN low, no clock needed):
  - O=0, TICK=0, BUSY=0
  - CNT=0, DIV_Q=2, state=IDLE
- Internal terms:
  - N = DIV_Q, the shadow ratio. sat(DIV) = max(DIV, 2).
  - H = N>>1 is the high-phase length. Low phase = N-H. Odd N gives the shorter high phase.
- States: IDLE, RUN, STOP.
- IDLE:
  - O=0, CNT holds 0.
  - EN=1 at an edge gives: state<=RUN, DIV_Q<=sat(DIV), CNT<=0, O<=1, TICK<=1, BUSY<=1.
  - O therefore rises at the first edge where EN is sampled high.
- RUN, at each edge:
  - Counter: CNT<=CNT+1, or 0 when CNT==N-1 (wrap).
  - High-to-low: CNT+1==H (no wrap) gives O<=0.
  - Wrap: O<=1, TICK<=1, DIV_Q<=sat(DIV). The new ratio takes effect from this period.
  - TICK=0 on every non-wrap edge.
  - EN=0 gives state<=STOP. Counting and O continue unchanged.
- STOP:
  - Counts exactly like RUN.
  - EN=1 before the wrap: return to RUN with no disturbance to CNT or O.
  - Wrap with EN=0: state<=IDLE, CNT<=0, O<=0 (stays low), TICK<=0, BUSY<=0.
  - Wrap with EN=1 on that same edge: behaves as a RUN wrap (restart). EN wins.
- DIV changes:
  - Mid-period changes are ignored until the next wrap.
  - Only the value sampled on the wrap edge is used.
- Period and duty: period = N CLK cycles. O high for H cycles, low for N-H cycles, exactly, every period.
- Glitch-free: O changes only on CLK rising edges, at most twice per period.
- Arithmetic:
  - CNT is W bits; compares are unsigned.
  - N-1 and CNT+1 are evaluated W+1 bits wide; no overflow is possible at N = 2^W-1.
- Mid-operation reset: any state returns asynchronously to reset values. Operation restarts from IDLE after RSTN rises.
- RSTN deassertion is assumed synchronised externally. The block adds no reset synchroniser.

Test Plan:
- RSTN 0->1, DIV=4, EN=1 held -> O per CLK: 1,1,0,0 repeating. TICK=1 on cycles 0,4,8,... BUSY=1 from the first edge.
- DIV=3 -> O: 1,0,0 repeating (H=1, low=2). DIV=15 with W=4 -> 7 high, 8 low, period 15.
- DIV=0 and DIV=1 -> identical to DIV=2: O 1,0 repeating. TICK every 2 cycles.
- Running DIV=4, DIV changed to 6 at CNT=1 -> current period finishes 1,1,0,0, next period 1,1,1,0,0,0. DIV toggled 4->7->4 within one period -> no effect on that period.
- EN dropped at CNT=1 of DIV=4 -> O completes 1,1,0,0, then stays 0. BUSY falls at the wrap edge, no TICK.
  - EN re-raised at CNT=2 during STOP -> waveform continues uninterrupted.
  - EN re-raised exactly on the wrap edge -> new period starts with TICK.
- RSTN pulsed low mid high-phase, no CLK edge -> O, TICK, BUSY go 0 immediately. After release with EN=1, first edge restarts with O=1, TICK=1.
